// File: rtl/parking_gate_scheduler.sv
// Shared parking gate sequencer: edge-detects entry/exit requests, arbitrates them
// round-robin, allocates or releases slots and holds the door open for DOOR_TICKS ticks.
module parking_gate_scheduler #(
    parameter int SLOTS      = 4,
    parameter int DOOR_TICKS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       entry_req,
    input  logic                       exit_req,
    input  logic [$clog2(SLOTS)-1:0]   exit_slot,
    input  logic                       tick,
    output logic [SLOTS-1:0]           occupancy,
    output logic                       door_open,
    output logic                       full_flag,
    output logic [$clog2(SLOTS+1)-1:0] free_count,
    output logic [$clog2(SLOTS)-1:0]   alloc_slot,
    output logic                       alloc_valid,
    output logic                       reject_pulse,
    output logic                       bad_exit_pulse,
    output logic                       busy
);

    localparam int SW = $clog2(SLOTS);
    localparam int FW = $clog2(SLOTS + 1);
    localparam int CW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS + 1) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_EXIT  = 3'd2;
    localparam logic [2:0] ST_OPEN  = 3'd3;
    localparam logic [2:0] ST_CLOSE = 3'd4;

    localparam logic SIDE_EXIT  = 1'b0;
    localparam logic SIDE_ENTRY = 1'b1;

    logic [2:0]       state_r;
    logic [SLOTS-1:0] occupancy_r;
    logic             door_open_r;
    logic [SW-1:0]    alloc_slot_r;
    logic             alloc_valid_r;
    logic             reject_pulse_r;
    logic             bad_exit_pulse_r;
    logic             entry_q_r;
    logic             exit_q_r;
    logic             entry_pend_r;
    logic             exit_pend_r;
    logic             last_served_r;
    logic [CW-1:0]    tick_cnt_r;

    logic             entry_rise_s;
    logic             exit_rise_s;
    logic             serve_entry_s;
    logic             serve_exit_s;
    logic [SW-1:0]    free_idx_s;

    function automatic logic [SW-1:0] lowest_free(input logic [SLOTS-1:0] occ);
        logic [SW-1:0] idx;
        idx = {SW{1'b0}};
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                idx = SW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [FW-1:0] popcount(input logic [SLOTS-1:0] occ);
        logic [FW-1:0] cnt;
        cnt = {FW{1'b0}};
        for (int i = 0; i < SLOTS; i++) begin
            cnt = cnt + FW'(occ[i]);
        end
        return cnt;
    endfunction

    assign entry_rise_s   = entry_req & ~entry_q_r;
    assign exit_rise_s    = exit_req & ~exit_q_r;
    assign free_idx_s     = lowest_free(occupancy_r);

    assign occupancy      = occupancy_r;
    assign door_open      = door_open_r;
    assign alloc_slot     = alloc_slot_r;
    assign alloc_valid    = alloc_valid_r;
    assign reject_pulse   = reject_pulse_r;
    assign bad_exit_pulse = bad_exit_pulse_r;
    assign full_flag      = &occupancy_r;
    assign free_count     = FW'(SLOTS) - popcount(occupancy_r);
    assign busy           = (state_r != ST_IDLE);

    // Round-robin pick in IDLE; on a tie the side not served last wins.
    always_comb begin
        serve_entry_s = 1'b0;
        serve_exit_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (entry_pend_r && (!exit_pend_r || (last_served_r == SIDE_EXIT))) begin
                serve_entry_s = 1'b1;
            end else if (exit_pend_r) begin
                serve_exit_s = 1'b1;
            end else begin
                serve_entry_s = 1'b0;
                serve_exit_s  = 1'b0;
            end
        end else begin
            serve_entry_s = 1'b0;
            serve_exit_s  = 1'b0;
        end
    end

    // Request capture, gate sequencing, slot bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            occupancy_r      <= {SLOTS{1'b0}};
            door_open_r      <= 1'b0;
            alloc_slot_r     <= {SW{1'b0}};
            alloc_valid_r    <= 1'b0;
            reject_pulse_r   <= 1'b0;
            bad_exit_pulse_r <= 1'b0;
            entry_q_r        <= 1'b0;
            exit_q_r         <= 1'b0;
            entry_pend_r     <= 1'b0;
            exit_pend_r      <= 1'b0;
            last_served_r    <= SIDE_EXIT;
            tick_cnt_r       <= {CW{1'b0}};
        end else begin
            entry_q_r        <= entry_req;
            exit_q_r         <= exit_req;
            // A fresh rise on the serving edge is a new request and stays pending.
            entry_pend_r     <= entry_rise_s | (entry_pend_r & ~serve_entry_s);
            exit_pend_r      <= exit_rise_s | (exit_pend_r & ~serve_exit_s);
            alloc_valid_r    <= 1'b0;
            reject_pulse_r   <= 1'b0;
            bad_exit_pulse_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (serve_entry_s) begin
                        last_served_r <= SIDE_ENTRY;
                        if (full_flag) begin
                            reject_pulse_r <= 1'b1;
                        end else begin
                            state_r <= ST_ENTRY;
                        end
                    end else if (serve_exit_s) begin
                        last_served_r <= SIDE_EXIT;
                        state_r       <= ST_EXIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ENTRY: begin
                    occupancy_r[free_idx_s] <= 1'b1;
                    alloc_slot_r            <= free_idx_s;
                    alloc_valid_r           <= 1'b1;
                    door_open_r             <= 1'b1;
                    tick_cnt_r              <= {CW{1'b0}};
                    state_r                 <= ST_OPEN;
                end
                ST_EXIT: begin
                    if (occupancy_r[exit_slot]) begin
                        occupancy_r[exit_slot] <= 1'b0;
                        door_open_r            <= 1'b1;
                        tick_cnt_r             <= {CW{1'b0}};
                        state_r                <= ST_OPEN;
                    end else begin
                        bad_exit_pulse_r <= 1'b1;
                        state_r          <= ST_IDLE;
                    end
                end
                ST_OPEN: begin
                    if (tick) begin
                        if (tick_cnt_r == CW'(DOOR_TICKS - 1)) begin
                            door_open_r <= 1'b0;
                            tick_cnt_r  <= {CW{1'b0}};
                            state_r     <= ST_CLOSE;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_CLOSE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    door_open_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Bench for parking_gate_scheduler: directed scenarios plus random single-request
// traffic checked against a slot-array model of the parking lot.
module tb_parking_gate_scheduler;

    logic       clk;
    logic       reset_n;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_slot;
    logic       tick;
    logic [3:0] occupancy;
    logic       door_open;
    logic       full_flag;
    logic [2:0] free_count;
    logic [1:0] alloc_slot;
    logic       alloc_valid;
    logic       reject_pulse;
    logic       bad_exit_pulse;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int tc = 0;
    int ticks_open = 0;
    int n_open = 0;
    int n_alloc = 0;

    parking_gate_scheduler #(.SLOTS(4), .DOOR_TICKS(4)) dut (
        .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .tick(tick), .occupancy(occupancy), .door_open(door_open),
        .full_flag(full_flag), .free_count(free_count), .alloc_slot(alloc_slot),
        .alloc_valid(alloc_valid), .reject_pulse(reject_pulse),
        .bad_exit_pulse(bad_exit_pulse), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; tick strobes every 10th cycle; door openings and ticks are tallied.
    task automatic step();
        logic door_before;
        logic tk;
        tick = (tc % 10 == 9);
        tk = tick;
        door_before = door_open;
        @(posedge clk);
        #1;
        tick = 1'b0;
        tc++;
        if (tk && door_before) ticks_open++;
        if (!door_before && door_open) begin
            n_open++;
            ticks_open = 0;
        end
        if (alloc_valid) n_alloc++;
    endtask

    // Wait (bounded) for the door to close; then the controller is in CLOSE.
    task automatic run_door();
        for (int k = 0; k < 200 && door_open; k++) step();
        chk("door_close_timeout", door_open, 32'd0);
        chk("door_tick_count", ticks_open, 32'd4);
        chk("close_busy", busy, 32'd1);
    endtask

    function automatic logic [3:0] pack(input bit m[4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m[i];
        return v;
    endfunction

    initial begin
        bit   occ_m[4];
        int   a0, o0, g, nocc, lf;
        bit   is_entry;
        logic [1:0] slot;

        reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0; tick = 1'b0;
        step(); step();
        chk("rst_occupancy", occupancy, 32'h0);
        chk("rst_door", door_open, 32'd0);
        chk("rst_full", full_flag, 32'd0);
        chk("rst_free", free_count, 32'd4);
        chk("rst_alloc_slot", alloc_slot, 32'd0);
        chk("rst_pulses", {alloc_valid, reject_pulse, bad_exit_pulse}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        reset_n = 1'b1;
        step();

        // Four entries fill slots 0..3 in order.
        for (int i = 0; i < 4; i++) begin
            entry_req = 1'b1; step(); entry_req = 1'b0;
            step();
            chk("entry_e1_busy", busy, 32'd1);
            chk("entry_e1_door", door_open, 32'd0);
            step();
            chk("entry_alloc_valid", alloc_valid, 32'd1);
            chk("entry_alloc_slot", alloc_slot, i);
            chk("entry_occupancy", occupancy, (32'd1 << (i + 1)) - 32'd1);
            chk("entry_door", door_open, 32'd1);
            step();
            chk("alloc_valid_one_cycle", alloc_valid, 32'd0);
            run_door();
            step();
            chk("idle_after_close", busy, 32'd0);
        end
        chk("full_flag", full_flag, 32'd1);
        chk("full_free", free_count, 32'd0);

        // Entry while full is refused for exactly one cycle.
        o0 = n_open;
        entry_req = 1'b1; step(); entry_req = 1'b0;
        step();
        chk("reject_pulse", reject_pulse, 32'd1);
        chk("reject_busy", busy, 32'd0);
        step();
        chk("reject_one_cycle", reject_pulse, 32'd0);
        for (int k = 0; k < 5; k++) step();
        chk("reject_no_door", n_open - o0, 32'd0);
        chk("reject_occupancy", occupancy, 32'hF);

        // Exit slot 2, then an entry reuses slot 2.
        exit_slot = 2'd2;
        exit_req = 1'b1; step(); exit_req = 1'b0;
        step(); step();
        chk("exit_occupancy", occupancy, 32'hB);
        chk("exit_door", door_open, 32'd1);
        run_door(); step();
        entry_req = 1'b1; step(); entry_req = 1'b0;
        step(); step();
        chk("reuse_alloc_slot", alloc_slot, 32'd2);
        chk("reuse_occupancy", occupancy, 32'hF);
        run_door(); step();

        // Build 0011 with exit served last, then tie between entry and exit.
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            entry_req = 1'b1; step(); entry_req = 1'b0;
            step(); step(); run_door(); step();
        end
        exit_slot = 2'd2;
        exit_req = 1'b1; step(); exit_req = 1'b0;
        step(); step(); run_door(); step();
        chk("tie_setup", occupancy, 32'h3);
        exit_slot = 2'd0;
        entry_req = 1'b1; exit_req = 1'b1; step(); entry_req = 1'b0; exit_req = 1'b0;
        step(); step();
        chk("tie_entry_first", occupancy, 32'h7);
        chk("tie_entry_alloc", alloc_valid, 32'd1);
        run_door();
        g = 0;
        do begin step(); g++; end while (!door_open && g < 20);
        chk("tie_gap_cycles", g, 32'd3);
        chk("tie_exit_second", occupancy, 32'h6);
        run_door(); step();

        // Three rises during one opening coalesce into a single extra grant.
        entry_req = 1'b1; step(); entry_req = 1'b0;
        step(); step();
        chk("coal_first_slot", alloc_slot, 32'd0);
        for (int k = 0; k < 3; k++) begin
            entry_req = 1'b1; step(); entry_req = 1'b0; step();
        end
        a0 = n_alloc; o0 = n_open;
        for (int k = 0; k < 150; k++) step();
        chk("coal_grants", n_alloc - a0, 32'd1);
        chk("coal_openings", n_open - o0, 32'd1);
        chk("coal_slot", alloc_slot, 32'd3);
        chk("coal_occupancy", occupancy, 32'hF);
        chk("coal_idle", busy, 32'd0);

        // Asynchronous reset while the door is open.
        exit_slot = 2'd3;
        exit_req = 1'b1; step(); exit_req = 1'b0;
        step(); step(); step(); step();
        chk("pre_reset_door", door_open, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_door", door_open, 32'd0);
        chk("async_rst_occupancy", occupancy, 32'h0);
        chk("async_rst_busy", busy, 32'd0);
        step(); reset_n = 1'b1; step();
        exit_slot = 2'd1;
        o0 = n_open;
        exit_req = 1'b1; step(); exit_req = 1'b0;
        step(); step();
        chk("bad_exit_pulse", bad_exit_pulse, 32'd1);
        chk("bad_exit_door", door_open, 32'd0);
        step();
        chk("bad_exit_one_cycle", bad_exit_pulse, 32'd0);
        chk("bad_exit_no_open", n_open - o0, 32'd0);

        // Random single requests against the slot-array model.
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
        for (int i = 0; i < 4; i++) occ_m[i] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            is_entry = ($urandom_range(0, 9) < 6);
            slot = 2'($urandom_range(0, 3));
            nocc = 0; lf = -1;
            for (int i = 0; i < 4; i++) begin
                if (occ_m[i]) nocc++;
                else if (lf < 0) lf = i;
            end
            exit_slot = slot;
            if (is_entry) entry_req = 1'b1; else exit_req = 1'b1;
            step();
            entry_req = 1'b0; exit_req = 1'b0;
            step();
            if (is_entry && nocc == 4) begin
                chk("rnd_reject", reject_pulse, 32'd1);
                step();
            end else begin
                step();
                if (is_entry) begin
                    chk("rnd_alloc_valid", alloc_valid, 32'd1);
                    chk("rnd_alloc_slot", alloc_slot, lf);
                    chk("rnd_entry_door", door_open, 32'd1);
                    occ_m[lf] = 1'b1;
                    run_door(); step();
                end else if (occ_m[slot]) begin
                    chk("rnd_exit_door", door_open, 32'd1);
                    occ_m[slot] = 1'b0;
                    run_door(); step();
                end else begin
                    chk("rnd_bad_exit", bad_exit_pulse, 32'd1);
                    chk("rnd_bad_exit_door", door_open, 32'd0);
                    step();
                end
            end
            nocc = 0;
            for (int i = 0; i < 4; i++) if (occ_m[i]) nocc++;
            chk("rnd_occupancy", occupancy, pack(occ_m));
            chk("rnd_free_count", free_count, 4 - nocc);
            chk("rnd_full_flag", full_flag, (nocc == 4) ? 32'd1 : 32'd0);
            chk("rnd_idle", busy, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
